// File: rtl/version_pkg.sv
// Build constants stamped by the release flow; consumed read-only by the reporter.
// Latency: none (constants only).
// Backpressure: not applicable.
package version_pkg;
   localparam logic [7:0]  C_VERSION_MAJOR  = 8'd0;
   localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
   localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
   localparam logic [7:0]  C_VERSION_BUILD  = 8'd46;
   localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
   localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
   localparam logic [7:0]  C_VERSION_DAY    = 8'h04;
   localparam logic [7:0]  C_VERSION_HOUR   = 8'h17;
   localparam logic [7:0]  C_VERSION_MINUTE = 8'h54;
   localparam logic [7:0]  C_VERSION_SECOND = 8'h28;
endpackage

// File: rtl/version_report_pkg.sv
// Token types, ASCII constants and helpers shared by the version banner serializer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package version_report_pkg;

   typedef enum logic [1:0] {TOK_LIT, TOK_DEC8, TOK_BCD2, TOK_BCD4} tok_kind_e;

   typedef struct packed {
      tok_kind_e   kind;
      logic [15:0] value;
   } tok_t;

   typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_e;

   localparam logic [7:0] C_ASCII_V     = 8'h76;
   localparam logic [7:0] C_ASCII_DOT   = 8'h2E;
   localparam logic [7:0] C_ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] C_ASCII_SPACE = 8'h20;
   localparam logic [7:0] C_ASCII_DASH  = 8'h2D;
   localparam logic [7:0] C_ASCII_COLON = 8'h3A;
   localparam logic [7:0] C_ASCII_CR    = 8'h0D;
   localparam logic [7:0] C_ASCII_LF    = 8'h0A;
   localparam logic [7:0] C_ASCII_ZERO  = 8'h30;
   localparam logic [7:0] C_ASCII_A     = 8'h41;

   function automatic tok_t mk_tok(tok_kind_e kind, logic [15:0] value);
      tok_t t;
      t.kind  = kind;
      t.value = value;
      return t;
   endfunction

   // Number of bytes a token expands to (1..4).
   function automatic logic [2:0] tok_len(tok_t tok);
      case (tok.kind)
         TOK_LIT:  return 3'd1;
         TOK_BCD2: return 3'd2;
         TOK_BCD4: return 3'd4;
         default: begin
            if (tok.value[7:0] >= 8'd100)     return 3'd3;
            else if (tok.value[7:0] >= 8'd10) return 3'd2;
            else                              return 3'd1;
         end
      endcase
   endfunction

   // Malformed BCD nibbles are shown as uppercase hex rather than dropped.
   function automatic logic [7:0] nib_to_ascii(logic [3:0] n);
      if (n < 4'd10) return C_ASCII_ZERO + {4'h0, n};
      else           return C_ASCII_A - 8'd10 + {4'h0, n};
   endfunction

endpackage

// File: rtl/version_reporter_if.sv
// Start/status and byte-stream signals between the banner reporter and its consumer.
// Latency: none (wiring only).
// Backpressure: tready_i stalls the byte stream; start_i is a level request.
interface version_reporter_if;
   logic       start_i;
   logic       busy_o;
   logic       done_o;
   logic [7:0] tdata_o;
   logic       tvalid_o;
   logic       tready_i;

   modport master (input start_i, tready_i, output busy_o, done_o, tdata_o, tvalid_o);
   modport slave  (output start_i, tready_i, input busy_o, done_o, tdata_o, tvalid_o);
endinterface

// File: rtl/version_reporter_bin8_to_bcd3.sv
// Combinational 8-bit binary to 3-digit BCD with significant-digit count.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
module bin8_to_bcd3 (
   input  logic [7:0]  bin,
   output logic [11:0] bcd,
   output logic [1:0]  n_dig
);

   logic [19:0] shift;

   // Double-dabble: add 3 to any digit >= 5, then shift in the next binary bit.
   always_comb begin
      shift = {12'h000, bin};
      for (int i = 0; i < 8; i++) begin
         if (shift[11:8]  > 4'd4) shift[11:8]  = shift[11:8]  + 4'd3;
         if (shift[15:12] > 4'd4) shift[15:12] = shift[15:12] + 4'd3;
         if (shift[19:16] > 4'd4) shift[19:16] = shift[19:16] + 4'd3;
         shift = shift << 1;
      end
      bcd = shift[19:8];
   end

   // Leading zeros are suppressed; zero itself still prints one digit.
   always_comb begin
      if (bcd[11:8] != 4'd0)     n_dig = 2'd3;
      else if (bcd[7:4] != 4'd0) n_dig = 2'd2;
      else                       n_dig = 2'd1;
   end

endmodule

// File: rtl/version_reporter.sv
// Serializes the build version/date constants as an ASCII banner on a byte stream.
// Latency: first byte 'v' valid the cycle after start_i is sampled in idle; then 1 byte/cycle.
// Backpressure: tready_i low holds tvalid_o/tdata_o; tready_i only feeds register enables.
module version_reporter #(
   parameter logic [7:0]  P_MAJOR  = version_pkg::C_VERSION_MAJOR,
   parameter logic [7:0]  P_MINOR  = version_pkg::C_VERSION_MINOR,
   parameter logic [7:0]  P_PATCH  = version_pkg::C_VERSION_PATCH,
   parameter logic [7:0]  P_BUILD  = version_pkg::C_VERSION_BUILD,
   parameter logic [15:0] P_YEAR   = version_pkg::C_VERSION_YEAR,
   parameter logic [7:0]  P_MONTH  = version_pkg::C_VERSION_MONTH,
   parameter logic [7:0]  P_DAY    = version_pkg::C_VERSION_DAY,
   parameter logic [7:0]  P_HOUR   = version_pkg::C_VERSION_HOUR,
   parameter logic [7:0]  P_MINUTE = version_pkg::C_VERSION_MINUTE,
   parameter logic [7:0]  P_SECOND = version_pkg::C_VERSION_SECOND,
   parameter bit          P_CRLF   = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   version_reporter_if.master  bus
);

   import version_report_pkg::*;

   localparam int         C_NUM_TOK  = P_CRLF ? 22 : 20;
   localparam logic [4:0] C_LAST_TOK = 5'(C_NUM_TOK - 1);

   // The CR/LF entries are simply never reached when P_CRLF is 0.
   localparam tok_t C_TOK_TABLE [22] = '{
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_V}),
      mk_tok(TOK_DEC8, {8'h00, P_MAJOR}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_DOT}),
      mk_tok(TOK_DEC8, {8'h00, P_MINOR}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_DOT}),
      mk_tok(TOK_DEC8, {8'h00, P_PATCH}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_PLUS}),
      mk_tok(TOK_DEC8, {8'h00, P_BUILD}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_SPACE}),
      mk_tok(TOK_BCD4, P_YEAR),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_DASH}),
      mk_tok(TOK_BCD2, {8'h00, P_MONTH}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_DASH}),
      mk_tok(TOK_BCD2, {8'h00, P_DAY}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_SPACE}),
      mk_tok(TOK_BCD2, {8'h00, P_HOUR}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_COLON}),
      mk_tok(TOK_BCD2, {8'h00, P_MINUTE}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_COLON}),
      mk_tok(TOK_BCD2, {8'h00, P_SECOND}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_CR}),
      mk_tok(TOK_LIT,  {8'h00, C_ASCII_LF})
   };

   state_e      state;
   logic [4:0]  tok_idx;
   logic [1:0]  dig_idx;
   logic [2:0]  cur_len;
   logic [7:0]  tdata_q;
   logic        tvalid_q;
   logic        busy_q;
   logic        done_q;

   logic        last_dig;
   logic        last_byte;
   logic [4:0]  sel_tok;
   logic [1:0]  sel_dig;
   tok_t        sel_entry;
   logic [11:0] dec_bcd;
   logic [1:0]  dec_n;
   logic [1:0]  dec_pos;
   logic [3:0]  sel_nib;
   logic [2:0]  sel_len;
   logic [7:0]  sel_byte;

   // cur_len is the length of the token currently on tdata_q, captured when it was loaded.
   assign last_dig  = ({1'b0, dig_idx} == (cur_len - 3'd1));
   assign last_byte = last_dig && (tok_idx == C_LAST_TOK);

   // Pointer to the byte to load next: first byte on start, otherwise the successor.
   always_comb begin
      sel_tok = tok_idx;
      sel_dig = dig_idx + 2'd1;
      if (state == ST_IDLE) begin
         sel_tok = '0;
         sel_dig = '0;
      end else if (last_dig) begin
         sel_tok = tok_idx + 5'd1;
         sel_dig = '0;
      end
   end

   assign sel_entry = (sel_tok <= C_LAST_TOK) ? C_TOK_TABLE[sel_tok] : C_TOK_TABLE[0];

   bin8_to_bcd3 u_bcd (
      .bin   (sel_entry.value[7:0]),
      .bcd   (dec_bcd),
      .n_dig (dec_n)
   );

   // Skip suppressed leading digits: position within {hundreds, tens, ones}.
   assign dec_pos = (2'd3 - dec_n) + sel_dig;

   // ASCII byte and token length for the selected pointer.
   always_comb begin
      sel_nib  = '0;
      sel_len  = tok_len(sel_entry);
      sel_byte = sel_entry.value[7:0];
      case (sel_entry.kind)
         TOK_DEC8: begin
            sel_len = {1'b0, dec_n};
            case (dec_pos)
               2'd0:    sel_nib = dec_bcd[11:8];
               2'd1:    sel_nib = dec_bcd[7:4];
               default: sel_nib = dec_bcd[3:0];
            endcase
            sel_byte = nib_to_ascii(sel_nib);
         end
         TOK_BCD2: begin
            sel_nib  = sel_dig[0] ? sel_entry.value[3:0] : sel_entry.value[7:4];
            sel_byte = nib_to_ascii(sel_nib);
         end
         TOK_BCD4: begin
            case (sel_dig)
               2'd0:    sel_nib = sel_entry.value[15:12];
               2'd1:    sel_nib = sel_entry.value[11:8];
               2'd2:    sel_nib = sel_entry.value[7:4];
               default: sel_nib = sel_entry.value[3:0];
            endcase
            sel_byte = nib_to_ascii(sel_nib);
         end
         default: ;
      endcase
   end

   // Control FSM with registered stream and status outputs; reset drops any partial banner.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tok_idx  <= '0;
         dig_idx  <= '0;
         cur_len  <= '0;
         tdata_q  <= 8'h00;
         tvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  state    <= ST_EMIT;
                  busy_q   <= 1'b1;
                  tvalid_q <= 1'b1;
                  tdata_q  <= sel_byte;
                  tok_idx  <= sel_tok;
                  dig_idx  <= sel_dig;
                  cur_len  <= sel_len;
               end
            end
            ST_EMIT: begin
               if (bus.tready_i) begin
                  if (last_byte) begin
                     state    <= ST_DONE;
                     busy_q   <= 1'b0;
                     tvalid_q <= 1'b0;
                     tdata_q  <= 8'h00;
                     done_q   <= 1'b1;
                  end else begin
                     tdata_q <= sel_byte;
                     tok_idx <= sel_tok;
                     dig_idx <= sel_dig;
                     cur_len <= sel_len;
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               tok_idx <= '0;
               dig_idx <= '0;
               cur_len <= '0;
            end
         endcase
      end
   end

   assign bus.tdata_o  = tdata_q;
   assign bus.tvalid_o = tvalid_q;
   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;

endmodule
